// File: rtl/guitar_hero_lane_renderer.sv
// Playfield renderer: N note lanes with falling note sprites, a hit line and
// hit flash, plus once-per-frame note scrolling, hit/miss/spawn handling and score.
module guitar_hero_lane_renderer #(
    parameter int          N_LANES      = 3,
    parameter int          LANE_W       = 208,
    parameter int          GAP_W        = 4,
    parameter int          H_ACTIVE     = 640,
    parameter int          V_ACTIVE     = 480,
    parameter int          NOTE_SLOTS   = 4,
    parameter int          NOTE_H       = 16,
    parameter int          SPEED        = 4,
    parameter int          HIT_Y        = 440,
    parameter int          HIT_TOL      = 8,
    parameter int          FLASH_FRAMES = 6,
    parameter logic [23:0] LANE_COLOR_A = 24'h00D5FF,
    parameter logic [23:0] LANE_COLOR_B = 24'hFF8900,
    parameter logic [23:0] NOTE_COLOR   = 24'hFFFFFF,
    parameter logic [23:0] LINE_COLOR   = 24'hC0C0C0,
    parameter logic [23:0] FLASH_COLOR  = 24'h00FF00
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9:0]         h_count,
    input  logic [9:0]         v_count,
    input  logic [N_LANES-1:0] note_spawn,
    input  logic [N_LANES-1:0] btn_hit,
    output logic [23:0]        rgb,
    output logic [N_LANES-1:0] hit_pulse,
    output logic [N_LANES-1:0] miss_pulse,
    output logic [N_LANES-1:0] spawn_drop,
    output logic [15:0]        score
);
    localparam int          FW     = $clog2(FLASH_FRAMES + 1);
    localparam logic [10:0] WIN_LO = 11'(HIT_Y - NOTE_H);
    localparam logic [10:0] WIN_HI = 11'(HIT_Y + HIT_TOL);

    logic [10:0] hx, vx;
    assign hx = {1'b0, h_count};
    assign vx = {1'b0, v_count};

    logic               tick;
    logic [N_LANES-1:0] spawn_pend, hit_pend;
    logic               slot_v_q [N_LANES][NOTE_SLOTS];
    logic [9:0]         slot_y_q [N_LANES][NOTE_SLOTS];
    logic [FW-1:0]      flash_q  [N_LANES];

    logic               slot_v_d [N_LANES][NOTE_SLOTS];
    logic [9:0]         slot_y_d [N_LANES][NOTE_SLOTS];
    logic [FW-1:0]      flash_d  [N_LANES];
    logic [15:0]        score_d;
    logic [N_LANES-1:0] hit_d, miss_d, drop_d;
    logic               hit_found, spawn_found;
    logic [10:0]        ny;
    logic [23:0]        pix;
    logic               note_here;

    // Frame update: hit, then move, then spawn, evaluated per lane only on the tick.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        slot_v_d    = slot_v_q;
        slot_y_d    = slot_y_q;
        flash_d     = flash_q;
        score_d     = score;
        hit_d       = '0;
        miss_d      = '0;
        drop_d      = '0;
        hit_found   = 1'b0;
        spawn_found = 1'b0;
        ny          = '0;
        if (tick) begin
            for (int i = 0; i < N_LANES; i++) begin
                hit_found = 1'b0;
                if (hit_pend[i]) begin
                    for (int s = 0; s < NOTE_SLOTS; s++) begin
                        if (!hit_found && slot_v_d[i][s] &&
                            {1'b0, slot_y_q[i][s]} >= WIN_LO &&
                            {1'b0, slot_y_q[i][s]} <= WIN_HI) begin
                            slot_v_d[i][s] = 1'b0;
                            hit_found      = 1'b1;
                        end
                    end
                end
                hit_d[i] = hit_found;
                if (hit_found && score_d != 16'hFFFF)
                    score_d = score_d + 16'd1;
                // Decrement acts on the old count, so a fresh hit shows for FLASH_FRAMES frames.
                if (hit_found)
                    flash_d[i] = FW'(FLASH_FRAMES);
                else if (flash_q[i] != '0)
                    flash_d[i] = flash_q[i] - FW'(1);

                for (int s = 0; s < NOTE_SLOTS; s++) begin
                    if (slot_v_d[i][s]) begin
                        ny = {1'b0, slot_y_q[i][s]} + 11'(SPEED);
                        if (ny >= 11'(V_ACTIVE)) begin
                            slot_v_d[i][s] = 1'b0;
                            miss_d[i]      = 1'b1;
                        end else begin
                            slot_y_d[i][s] = ny[9:0];
                        end
                    end
                end

                spawn_found = 1'b0;
                if (spawn_pend[i]) begin
                    for (int s = 0; s < NOTE_SLOTS; s++) begin
                        if (!spawn_found && !slot_v_d[i][s]) begin
                            slot_v_d[i][s] = 1'b1;
                            slot_y_d[i][s] = '0;
                            spawn_found    = 1'b1;
                        end
                    end
                    drop_d[i] = !spawn_found;
                end
            end
        end
    end

    always_comb begin
        pix       = '0;
        note_here = 1'b0;
        if (hx < 11'(H_ACTIVE) && vx < 11'(V_ACTIVE)) begin
            for (int i = 0; i < N_LANES; i++) begin
                if (hx >= 11'(GAP_W + i * (LANE_W + GAP_W)) &&
                    hx <  11'(GAP_W + i * (LANE_W + GAP_W) + LANE_W)) begin
                    note_here = 1'b0;
                    for (int s = 0; s < NOTE_SLOTS; s++) begin
                        if (slot_v_q[i][s] && vx >= {1'b0, slot_y_q[i][s]} &&
                            vx < {1'b0, slot_y_q[i][s]} + 11'(NOTE_H))
                            note_here = 1'b1;
                    end
                    if (note_here)
                        pix = NOTE_COLOR;
                    else if (vx >= 11'(HIT_Y) && vx < 11'(HIT_Y + 2))
                        pix = (flash_q[i] != '0) ? FLASH_COLOR : LINE_COLOR;
                    else
                        pix = (i % 2 == 0) ? LANE_COLOR_A : LANE_COLOR_B;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick       <= 1'b0;
            spawn_pend <= '0;
            hit_pend   <= '0;
            rgb        <= '0;
            hit_pulse  <= '0;
            miss_pulse <= '0;
            spawn_drop <= '0;
            score      <= '0;
            // NOTE: the slot array is reset in full; a reset must clear the playfield at once.
            for (int i = 0; i < N_LANES; i++) begin
                flash_q[i] <= '0;
                for (int s = 0; s < NOTE_SLOTS; s++) begin
                    slot_v_q[i][s] <= 1'b0;
                    slot_y_q[i][s] <= '0;
                end
            end
        end else begin
            tick       <= (h_count == 10'd0) && (vx == 11'(V_ACTIVE));
            // A request arriving on the tick itself survives for the next frame.
            spawn_pend <= tick ? note_spawn : (spawn_pend | note_spawn);
            hit_pend   <= tick ? btn_hit    : (hit_pend | btn_hit);
            rgb        <= pix;
            hit_pulse  <= hit_d;
            miss_pulse <= miss_d;
            spawn_drop <= drop_d;
            score      <= score_d;
            slot_v_q   <= slot_v_d;
            slot_y_q   <= slot_y_d;
            flash_q    <= flash_d;
        end
    end
endmodule

// File: tb/tb_guitar_hero_lane_renderer.sv
// Self-checking bench: constant vector tables, directed frame sequences and
// randomized requests/pixels compared against a frame-level playfield model.
module tb_guitar_hero_lane_renderer;
    localparam int NL      = 3;
    localparam int LANE_W  = 208;
    localparam int GAP     = 4;
    localparam int H_ACT   = 640;
    localparam int V_ACT   = 480;
    localparam int NS      = 4;
    localparam int NOTE_H  = 16;
    localparam int SPEED   = 4;
    localparam int HIT_Y   = 440;
    localparam int HIT_TOL = 8;
    localparam int FLASH   = 6;
    localparam logic [23:0] CA = 24'h00D5FF;
    localparam logic [23:0] CB = 24'hFF8900;
    localparam logic [23:0] CN = 24'hFFFFFF;
    localparam logic [23:0] CL = 24'hC0C0C0;
    localparam logic [23:0] CF = 24'h00FF00;

    logic          clk = 1'b0;
    logic          rst;
    logic [9:0]    h_count, v_count;
    logic [NL-1:0] note_spawn, btn_hit;
    logic [23:0]   rgb;
    logic [NL-1:0] hit_pulse, miss_pulse, spawn_drop;
    logic [15:0]   score;

    guitar_hero_lane_renderer dut (
        .clk        (clk),
        .rst        (rst),
        .h_count    (h_count),
        .v_count    (v_count),
        .note_spawn (note_spawn),
        .btn_hit    (btn_hit),
        .rgb        (rgb),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .spawn_drop (spawn_drop),
        .score      (score)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Playfield model: notes as (valid, y) per lane slot, advanced one frame at a time.
    bit          m_v [NL][NS];
    int          m_y [NL][NS];
    int          m_flash [NL];
    int          m_score;
    logic [NL-1:0] m_ps, m_ph;
    bit          m_tick;
    logic [NL-1:0] e_hit, e_miss, e_drop;
    logic [23:0] e_rgb;

    function automatic void model_reset();
        for (int l = 0; l < NL; l++) begin
            m_flash[l] = 0;
            for (int s = 0; s < NS; s++) begin
                m_v[l][s] = 0;
                m_y[l][s] = 0;
            end
        end
        m_score = 0; m_ps = '0; m_ph = '0; m_tick = 0;
        e_hit = '0; e_miss = '0; e_drop = '0; e_rgb = '0;
    endfunction

    function automatic logic [23:0] model_pixel(input int h, input int v);
        int lane, off;
        if (h >= H_ACT || v >= V_ACT || h < GAP) return '0;
        lane = (h - GAP) / (LANE_W + GAP);
        off  = (h - GAP) % (LANE_W + GAP);
        if (lane >= NL || off >= LANE_W) return '0;
        for (int s = 0; s < NS; s++)
            if (m_v[lane][s] && v >= m_y[lane][s] && v < m_y[lane][s] + NOTE_H) return CN;
        if (v == HIT_Y || v == HIT_Y + 1) return (m_flash[lane] > 0) ? CF : CL;
        return (lane % 2 == 0) ? CA : CB;
    endfunction

    function automatic void model_frame();
        for (int l = 0; l < NL; l++) begin
            bit hit = 0;
            bit placed = 0;
            if (m_ph[l]) begin
                for (int s = 0; s < NS && !hit; s++) begin
                    if (m_v[l][s] && m_y[l][s] >= HIT_Y - NOTE_H && m_y[l][s] <= HIT_Y + HIT_TOL) begin
                        m_v[l][s] = 0;
                        hit = 1;
                    end
                end
            end
            e_hit[l] = hit;
            if (hit) m_score = (m_score < 65535) ? m_score + 1 : 65535;
            m_flash[l] = hit ? FLASH : ((m_flash[l] > 0) ? m_flash[l] - 1 : 0);
            for (int s = 0; s < NS; s++) begin
                if (m_v[l][s]) begin
                    m_y[l][s] += SPEED;
                    if (m_y[l][s] >= V_ACT) begin
                        m_v[l][s] = 0;
                        e_miss[l] = 1;
                    end
                end
            end
            if (m_ps[l]) begin
                for (int s = 0; s < NS && !placed; s++) begin
                    if (!m_v[l][s]) begin
                        m_v[l][s] = 1;
                        m_y[l][s] = 0;
                        placed = 1;
                    end
                end
                e_drop[l] = !placed;
            end
        end
    endfunction

    function automatic void model_edge(input int h, input int v, input logic [NL-1:0] sp,
                                       input logic [NL-1:0] bh);
        e_hit = '0; e_miss = '0; e_drop = '0;
        if (m_tick) begin
            model_frame();
            m_ps = sp;
            m_ph = bh;
        end else begin
            m_ps = m_ps | sp;
            m_ph = m_ph | bh;
        end
        m_tick = (h == 0 && v == V_ACT);
    endfunction

    // One clock with given counters/requests; every cycle is compared with the model.
    task automatic cyc(input int h, input int v, input logic [NL-1:0] sp, input logic [NL-1:0] bh);
        logic [23:0] nxt;
        h_count = 10'(h); v_count = 10'(v); note_spawn = sp; btn_hit = bh;
        nxt = model_pixel(h, v);
        @(posedge clk);
        model_edge(h, v, sp, bh);
        e_rgb = nxt;
        #1;
        note_spawn = '0; btn_hit = '0;
        check("model_rgb", rgb, e_rgb);
        check("model_pulses", {hit_pulse, miss_pulse, spawn_drop}, {e_hit, e_miss, e_drop});
        check("model_score", score, 32'(m_score));
    endtask

    // Counters reach (0,V_ACTIVE), then the tick cycle; frame results are visible on return.
    task automatic frame_tick(input logic [NL-1:0] sp_on_tick, input logic [NL-1:0] bh_on_tick);
        cyc(0, V_ACT, '0, '0);
        cyc(0, V_ACT + 1, sp_on_tick, bh_on_tick);
    endtask

    task automatic px(input string name, input int h, input int v, input logic [23:0] exp);
        cyc(h, v, '0, '0);
        check(name, rgb, exp);
    endtask

    function automatic logic [NL-1:0] rand_req(input int one_in);
        logic [NL-1:0] r;
        for (int l = 0; l < NL; l++) r[l] = ($urandom_range(0, one_in - 1) == 0);
        return r;
    endfunction

    typedef struct packed {
        logic [9:0]  h;
        logic [9:0]  v;
        logic [23:0] exp;
    } pix_vec_t;

    pix_vec_t tbl [20];

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int misses, miss_at, n, h, v, l, s, r;

        tbl[0]  = '{10'd0,   10'd0,   24'h000000};
        tbl[1]  = '{10'd3,   10'd100, 24'h000000};
        tbl[2]  = '{10'd4,   10'd100, CA};
        tbl[3]  = '{10'd211, 10'd0,   CA};
        tbl[4]  = '{10'd212, 10'd100, 24'h000000};
        tbl[5]  = '{10'd215, 10'd100, 24'h000000};
        tbl[6]  = '{10'd216, 10'd100, CB};
        tbl[7]  = '{10'd423, 10'd479, CB};
        tbl[8]  = '{10'd424, 10'd100, 24'h000000};
        tbl[9]  = '{10'd428, 10'd100, CA};
        tbl[10] = '{10'd635, 10'd100, CA};
        tbl[11] = '{10'd636, 10'd100, 24'h000000};
        tbl[12] = '{10'd640, 10'd100, 24'h000000};
        tbl[13] = '{10'd100, 10'd439, CA};
        tbl[14] = '{10'd100, 10'd440, CL};
        tbl[15] = '{10'd300, 10'd441, CL};
        tbl[16] = '{10'd500, 10'd442, CA};
        tbl[17] = '{10'd100, 10'd480, 24'h000000};
        tbl[18] = '{10'd1000, 10'd50, 24'h000000};
        tbl[19] = '{10'd300, 10'd0,   CB};

        rst = 1'b0; h_count = 10'd100; v_count = 10'd100; note_spawn = '0; btn_hit = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_rgb", rgb, 24'h0);
        check("reset_pulses", {hit_pulse, miss_pulse, spawn_drop}, 9'h0);
        check("reset_score", score, 16'h0);
        rst = 1'b1;

        frame_tick('0, '0);
        for (int i = 0; i < 20; i++)
            px($sformatf("empty_frame[%0d]", i), tbl[i].h, tbl[i].v, tbl[i].exp);

        // Lane 0 note from spawn to exit.
        cyc(100, 100, 3'b001, '0);
        frame_tick('0, '0);
        px("l0_note_top", 100, 0, CN);
        px("l0_note_bot", 100, 15, CN);
        px("l0_below_note", 100, 16, CA);
        px("l1_no_note", 300, 0, CB);
        misses = 0; miss_at = -1;
        for (int k = 1; k <= 120; k++) begin
            frame_tick('0, '0);
            if (miss_pulse[0]) begin
                misses++;
                miss_at = k;
            end
        end
        check("l0_miss_count", misses, 1);
        check("l0_miss_tick", miss_at, 120);
        px("l0_freed", 100, 0, CA);

        // Requests on the tick cycle itself wait for the following tick.
        frame_tick(3'b111, 3'b111);
        check("tickreq_no_early_spawn", spawn_drop | hit_pulse, 3'b000);
        px("tickreq_l0_empty", 100, 0, CA);
        frame_tick('0, '0);
        check("tickreq_new_note_not_hit", hit_pulse, 3'b000);
        px("tickreq_l0_note", 100, 0, CN);
        px("tickreq_l1_note", 300, 0, CN);
        px("tickreq_l2_note", 500, 5, CN);
        frame_tick('0, '0);
        px("tickreq_once_row3", 100, 3, CA);
        px("tickreq_once_row4", 100, 4, CN);
        for (int k = 0; k < 108; k++) frame_tick('0, '0);
        px("y436_note", 100, 436, CN);
        px("y436_above", 100, 435, CA);
        px("note_over_line", 300, 440, CN);
        cyc(100, 100, '0, 3'b111);
        frame_tick('0, '0);
        check("hit_all_pulse", hit_pulse, 3'b111);
        check("hit_all_score", score, 16'd3);
        px("flash_frame1", 300, 440, CF);
        for (int k = 2; k <= 6; k++) begin
            frame_tick('0, '0);
            px($sformatf("flash_frame%0d", k), 300, 441, CF);
        end
        frame_tick('0, '0);
        px("flash_over", 300, 440, CL);

        // Hit request with the note far above the window.
        cyc(100, 100, 3'b010, '0);
        frame_tick('0, '0);
        for (int k = 0; k < 25; k++) frame_tick('0, '0);
        px("l1_y100_note", 300, 100, CN);
        cyc(100, 100, '0, 3'b010);
        frame_tick('0, '0);
        check("early_hit_pulse", hit_pulse, 3'b000);
        check("early_hit_score", score, 16'd3);

        // Five spawns into a four-slot lane.
        for (int k = 1; k <= 5; k++) begin
            cyc(100, 100, 3'b100, '0);
            frame_tick('0, '0);
            check($sformatf("l2_drop_%0d", k), spawn_drop, (k == 5) ? 3'b100 : 3'b000);
        end
        px("l2_stack_row3", 500, 3, CA);
        px("l2_stack_row4", 500, 4, CN);
        px("l2_stack_row31", 500, 31, CN);
        px("l2_stack_row32", 500, 32, CA);

        // Asynchronous reset mid-frame with live notes and nonzero score.
        px("pre_reset_note", 500, 10, CN);
        #3;
        rst = 1'b0;
        #1;
        check("midreset_rgb", rgb, 24'h0);
        check("midreset_score", score, 16'h0);
        @(posedge clk);
        #1;
        check("inreset_rgb", rgb, 24'h0);
        rst = 1'b1;
        model_reset();
        frame_tick('0, '0);
        px("post_reset_l2", 500, 10, CA);
        px("post_reset_line", 300, 440, CL);
        check("post_reset_score", score, 16'h0);

        // Randomized requests and pixel sampling against the model.
        for (int f = 0; f < 300; f++) begin
            n = $urandom_range(6, 16);
            for (int k = 0; k < n; k++) begin
                r = $urandom_range(0, 3);
                l = $urandom_range(0, NL - 1);
                s = $urandom_range(0, NS - 1);
                h = GAP + l * (LANE_W + GAP) + $urandom_range(0, LANE_W - 1);
                if (r == 0) begin
                    h = $urandom_range(0, 700);
                    v = $urandom_range(0, 520);
                end else if (r == 1 && m_v[l][s]) begin
                    v = m_y[l][s] + $urandom_range(0, NOTE_H + 3) - 2;
                    if (v < 0) v = 0;
                end else if (r == 2) begin
                    v = HIT_Y - 1 + $urandom_range(0, 3);
                end else begin
                    v = $urandom_range(0, V_ACT - 1);
                end
                cyc(h, v, rand_req(40), rand_req(12));
            end
            cyc(0, V_ACT, '0, '0);
            cyc(0, V_ACT + 1, rand_req(8), rand_req(8));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
